// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction-fetch (I) and load/store (D)
// requesters; one outstanding access, registered responses, latency watchdog in WAIT.
module mem_port_arbiter #(
    parameter int unsigned AW      = 30,
    parameter int unsigned DW      = 32,
    parameter int unsigned DPRIO   = 1,
    parameter int unsigned TMO_CYC = 255
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          IREQ,
    input  logic [AW-1:0] IADDR,
    output logic          IACK,
    output logic          IVALID,
    output logic [DW-1:0] IRDATA,
    input  logic          DREQ,
    input  logic          DRW,
    input  logic [AW-1:0] DADDR,
    input  logic [DW-1:0] DWDATA,
    output logic          DACK,
    output logic          DVALID,
    output logic [DW-1:0] DRDATA,
    output logic          MREQ,
    output logic          MRW,
    output logic [AW-1:0] MADDR,
    output logic [DW-1:0] MWDATA,
    input  logic          MACK,
    input  logic          MVALID,
    input  logic [DW-1:0] MRDATA,
    output logic          BUSY,
    output logic          TMO_ERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [15:0] WDOG_LAST = 16'(TMO_CYC - 1);
    localparam logic        D_FIRST   = (DPRIO != 0);

    state_t      state;
    logic        own_d;
    logic        last_d;
    logic [15:0] wdog;
    logic        pick_d;
    logic        wdog_done;

    // D wins if it is the only requester, or on a tie when prioritised or when I was granted last
    assign pick_d    = DREQ & (~IREQ | D_FIRST | ~last_d);
    assign wdog_done = (wdog == WDOG_LAST);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= S_IDLE;
            own_d   <= 1'b0;
            last_d  <= 1'b0;
            wdog    <= '0;
            MRW     <= 1'b0;
            MADDR   <= '0;
            MWDATA  <= '0;
            IRDATA  <= '0;
            DRDATA  <= '0;
            TMO_ERR <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (IREQ || DREQ) begin
                        own_d  <= pick_d;
                        last_d <= pick_d;
                        MADDR  <= pick_d ? DADDR : IADDR;
                        MRW    <= pick_d & DRW;
                        MWDATA <= pick_d ? DWDATA : '0;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (MACK) begin
                        wdog  <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // MVALID takes precedence over an expiring watchdog
                    if (MVALID) begin
                        if (own_d) DRDATA <= MRW ? '0 : MRDATA;
                        else       IRDATA <= MRDATA;
                        state <= S_RESP;
                    end else if (wdog_done) begin
                        TMO_ERR <= 1'b1;
                        if (own_d) DRDATA <= '0;
                        else       IRDATA <= '0;
                        state <= S_RESP;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        MREQ   = (state == S_ISSUE);
        IACK   = MREQ & MACK & ~own_d;
        DACK   = MREQ & MACK & own_d;
        IVALID = (state == S_RESP) & ~own_d;
        DVALID = (state == S_RESP) & own_d;
        BUSY   = (state != S_IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a (DPRIO=1) and instance b (DPRIO=0)
// share all inputs; both use an 8-cycle watchdog.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        IREQ, DREQ, DRW, MACK, MVALID;
    logic [29:0] IADDR, DADDR;
    logic [31:0] DWDATA, MRDATA;

    logic        IACK, IVALID, DACK, DVALID, MREQ, MRW, BUSY, TMO_ERR;
    logic [31:0] IRDATA, DRDATA, MWDATA;
    logic [29:0] MADDR;

    logic        b_IACK, b_IVALID, b_DACK, b_DVALID, b_MREQ, b_MRW, b_BUSY, b_TMO_ERR;
    logic [31:0] b_IRDATA, b_DRDATA, b_MWDATA;
    logic [29:0] b_MADDR;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.AW(30), .DW(32), .DPRIO(1), .TMO_CYC(8)) u_a (
        .CLK(CLK), .RSTN(RSTN),
        .IREQ(IREQ), .IADDR(IADDR), .IACK(IACK), .IVALID(IVALID), .IRDATA(IRDATA),
        .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
        .DACK(DACK), .DVALID(DVALID), .DRDATA(DRDATA),
        .MREQ(MREQ), .MRW(MRW), .MADDR(MADDR), .MWDATA(MWDATA),
        .MACK(MACK), .MVALID(MVALID), .MRDATA(MRDATA),
        .BUSY(BUSY), .TMO_ERR(TMO_ERR)
    );

    mem_port_arbiter #(.AW(30), .DW(32), .DPRIO(0), .TMO_CYC(8)) u_b (
        .CLK(CLK), .RSTN(RSTN),
        .IREQ(IREQ), .IADDR(IADDR), .IACK(b_IACK), .IVALID(b_IVALID), .IRDATA(b_IRDATA),
        .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
        .DACK(b_DACK), .DVALID(b_DVALID), .DRDATA(b_DRDATA),
        .MREQ(b_MREQ), .MRW(b_MRW), .MADDR(b_MADDR), .MWDATA(b_MWDATA),
        .MACK(MACK), .MVALID(MVALID), .MRDATA(MRDATA),
        .BUSY(b_BUSY), .TMO_ERR(b_TMO_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One access with immediate MACK and MVALID on the following cycle; starts in IDLE.
    task automatic access(input bit a_d, input bit b_d, input bit check_b, input bit drop,
                          input logic [31:0] rd);
        tick();
        MACK = 1'b1;
        #1;
        chk("acc_dack", DACK, a_d);
        chk("acc_iack", IACK, !a_d);
        chk("acc_maddr", MADDR, a_d ? DADDR : IADDR);
        if (check_b) chk("acc_b_dack", b_DACK, b_d);
        tick();
        MACK = 1'b0;
        if (drop) begin
            if (a_d) DREQ = 1'b0;
            else     IREQ = 1'b0;
        end
        MVALID = 1'b1;
        MRDATA = rd;
        #1;
        chk("acc_mreq_wait", MREQ, 0);
        tick();
        MVALID = 1'b0;
        #1;
        chk("acc_valid", a_d ? DVALID : IVALID, 1);
        chk("acc_other_valid", a_d ? IVALID : DVALID, 0);
        chk("acc_rdata", a_d ? DRDATA : IRDATA, (a_d && DRW) ? 32'h0 : rd);
        if (check_b) begin
            chk("acc_b_dvalid", b_DVALID, b_d);
            chk("acc_b_rdata", b_d ? b_DRDATA : b_IRDATA, rd);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, observed hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        IREQ = 0; DREQ = 0; DRW = 0; MACK = 0; MVALID = 0;
        IADDR = '0; DADDR = '0; DWDATA = '0; MRDATA = '0;

        // Reset state
        tick(); tick();
        chk("rst_mreq", MREQ, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_maddr", MADDR, 0);
        chk("rst_irdata", IRDATA, 0);
        chk("rst_drdata", DRDATA, 0);
        chk("rst_tmo", TMO_ERR, 0);
        RSTN = 1'b1;

        // I read
        IREQ = 1; IADDR = 30'h10;
        #1 chk("ird_idle_busy", BUSY, 0);
        tick();
        #1;
        chk("ird_mreq", MREQ, 1);
        chk("ird_maddr", MADDR, 32'h10);
        chk("ird_mrw", MRW, 0);
        MACK = 1;
        #1;
        chk("ird_iack", IACK, 1);
        chk("ird_dack", DACK, 0);
        tick();
        MACK = 0; IREQ = 0; IADDR = 30'h3FF;
        #1;
        chk("ird_wait_mreq", MREQ, 0);
        chk("ird_wait_iack", IACK, 0);
        chk("ird_wait_busy", BUSY, 1);
        tick();
        MVALID = 1; MRDATA = 32'hDEADBEEF;
        #1 chk("ird_no_early_valid", IVALID, 0);
        tick();
        MVALID = 0; MRDATA = 0;
        #1;
        chk("ird_ivalid", IVALID, 1);
        chk("ird_irdata", IRDATA, 32'hDEADBEEF);
        chk("ird_dvalid", DVALID, 0);
        tick();
        #1;
        chk("ird_ivalid_pulse", IVALID, 0);
        chk("ird_idle", BUSY, 0);
        chk("ird_hold", IRDATA, 32'hDEADBEEF);

        // Stray MACK/MVALID in IDLE are ignored
        MVALID = 1; MACK = 1;
        tick();
        #1;
        chk("stray_busy", BUSY, 0);
        chk("stray_ivalid", IVALID, 0);
        chk("stray_hold", IRDATA, 32'hDEADBEEF);
        MVALID = 0; MACK = 0;

        // D write with MACK delayed 3 cycles
        DREQ = 1; DRW = 1; DADDR = 30'h20; DWDATA = 32'h12345678;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dwr_mreq", MREQ, 1);
            chk("dwr_maddr", MADDR, 32'h20);
            chk("dwr_mwdata", MWDATA, 32'h12345678);
            chk("dwr_mrw", MRW, 1);
            chk("dwr_no_dack", DACK, 0);
            tick();
        end
        MACK = 1;
        #1;
        chk("dwr_dack", DACK, 1);
        chk("dwr_iack", IACK, 0);
        tick();
        MACK = 0; DREQ = 0; DADDR = 30'h3; DWDATA = 0;
        MVALID = 1; MRDATA = 32'hAAAA5555;
        #1 chk("dwr_latched_addr", MADDR, 32'h20);
        tick();
        MVALID = 0;
        #1;
        chk("dwr_dvalid", DVALID, 1);
        chk("dwr_drdata", DRDATA, 0);
        chk("dwr_ivalid", IVALID, 0);
        chk("dwr_irdata_kept", IRDATA, 32'hDEADBEEF);
        tick();
        #1 chk("dwr_dvalid_pulse", DVALID, 0);

        // Tie on instance a (DPRIO=1): D first, then I
        IREQ = 1; DREQ = 1; DRW = 0; IADDR = 30'h40; DADDR = 30'h50;
        access(1'b1, 1'b0, 1'b0, 1'b1, 32'h11112222);
        #1 chk("tie_gap_mreq", MREQ, 0);
        access(1'b0, 1'b0, 1'b0, 1'b1, 32'h33334444);

        // Round robin on instance b (DPRIO=0) after reset: I alone, then ties D,I,D,I
        RSTN = 0;
        tick();
        RSTN = 1;
        IREQ = 1; IADDR = 30'h70;
        access(1'b0, 1'b0, 1'b1, 1'b1, 32'h70707070);
        IREQ = 1; DREQ = 1; DRW = 0; DADDR = 30'h80;
        access(1'b1, 1'b1, 1'b1, 1'b0, 32'hA0000001);
        access(1'b1, 1'b0, 1'b1, 1'b0, 32'hA0000002);
        access(1'b1, 1'b1, 1'b1, 1'b0, 32'hA0000003);
        access(1'b1, 1'b0, 1'b1, 1'b0, 32'hA0000004);
        IREQ = 0; DREQ = 0;

        // MVALID on the final watchdog cycle wins with no error
        IREQ = 1; IADDR = 30'h90;
        tick();
        MACK = 1;
        #1 chk("lastcyc_iack", IACK, 1);
        tick();
        MACK = 0; IREQ = 0;
        repeat (7) tick();
        MVALID = 1; MRDATA = 32'hCAFEF00D;
        #1;
        chk("lastcyc_busy", BUSY, 1);
        chk("lastcyc_no_valid", IVALID, 0);
        tick();
        MVALID = 0;
        #1;
        chk("lastcyc_ivalid", IVALID, 1);
        chk("lastcyc_irdata", IRDATA, 32'hCAFEF00D);
        chk("lastcyc_tmo", TMO_ERR, 0);
        tick();

        // Timeout: 8 WAIT cycles without MVALID
        IREQ = 1; IADDR = 30'hA0;
        tick();
        MACK = 1;
        #1 chk("tmo_iack", IACK, 1);
        tick();
        MACK = 0; IREQ = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("tmo_wait_valid", IVALID, 0);
            chk("tmo_wait_err", TMO_ERR, 0);
            tick();
        end
        #1;
        chk("tmo_ivalid", IVALID, 1);
        chk("tmo_irdata", IRDATA, 0);
        chk("tmo_err", TMO_ERR, 1);
        tick();
        #1;
        chk("tmo_sticky", TMO_ERR, 1);
        chk("tmo_idle", BUSY, 0);

        // Reset in ISSUE drops MREQ at once
        IREQ = 1; IADDR = 30'hB0;
        tick();
        #1 chk("rst_issue_mreq_before", MREQ, 1);
        RSTN = 0;
        #1;
        chk("rst_issue_mreq", MREQ, 0);
        chk("rst_issue_tmo", TMO_ERR, 0);
        IREQ = 0;
        tick();
        RSTN = 1;

        // Reset in WAIT abandons the access
        IREQ = 1; IADDR = 30'hB4;
        tick();
        MACK = 1;
        tick();
        MACK = 0; IREQ = 0;
        #1 chk("rst_wait_busy_before", BUSY, 1);
        RSTN = 0;
        #1;
        chk("rst_wait_busy", BUSY, 0);
        chk("rst_wait_mreq", MREQ, 0);
        chk("rst_wait_ivalid", IVALID, 0);
        MVALID = 1; MRDATA = 32'h1;
        tick();
        RSTN = 1;
        tick();
        #1 chk("rst_wait_no_valid", IVALID, 0);
        MVALID = 0;
        IREQ = 1; IADDR = 30'hC0;
        access(1'b0, 1'b0, 1'b0, 1'b1, 32'h0BADC0DE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
